// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file arbiter: FSM state encoding and requester ids.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD     = 2'd1,
        RD_CAP = 2'd2,
        WR     = 2'd3
    } state_t;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester-side bus of the register-file arbiter: req/gnt handshake, operands and responses.
interface regfile_arbiter_if #(
    parameter int DataSize = 32,
    parameter int AddrSize = 5
) ();

    logic [1:0]            req;
    logic [1:0]            we;
    logic [2*AddrSize-1:0] req_addr1;
    logic [2*AddrSize-1:0] req_addr2;
    logic [2*DataSize-1:0] req_wdata;
    logic [1:0]            gnt;
    logic [1:0]            rvalid;
    logic [1:0]            wdone;
    logic [DataSize-1:0]   rdata1;
    logic [DataSize-1:0]   rdata2;
    logic                  busy;

    modport master (
        output req, we, req_addr1, req_addr2, req_wdata,
        input  gnt, rvalid, wdone, rdata1, rdata2, busy
    );

    modport slave (
        input  req, we, req_addr1, req_addr2, req_wdata,
        output gnt, rvalid, wdone, rdata1, rdata2, busy
    );

endinterface

// File: rtl/regfile_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is chosen.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt,
    output logic       winner
);

    // Winner selection and one-hot grant
    always_comb begin
        winner = REQ_CORE;
        gnt    = 2'b00;
        case (req)
            2'b01: begin
                winner = REQ_CORE;
                gnt    = 2'b01;
            end
            2'b10: begin
                winner = REQ_DBG;
                gnt    = 2'b10;
            end
            2'b11: begin
                if (last_gnt == REQ_CORE) begin
                    winner = REQ_DBG;
                    gnt    = 2'b10;
                end else begin
                    winner = REQ_CORE;
                    gnt    = 2'b01;
                end
            end
            default: begin
                winner = REQ_CORE;
                gnt    = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/regfile_arbiter_sva.sv
// Protocol checker for the register-file arbiter: enable exclusivity, pulse encoding, busy.
module regfile_arbiter_sva
    import regfile_pkg::*;
(
    input logic       clock,
    input logic       reset,
    input state_t     state,
    input logic       busy,
    input logic [1:0] gnt,
    input logic [1:0] rvalid,
    input logic [1:0] wdone,
    input logic       enable_fetch,
    input logic       enable_writeback
);

    a_enables_exclusive: assert property (@(posedge clock) disable iff (reset)
        !(enable_fetch && enable_writeback));
    a_gnt_onehot0:       assert property (@(posedge clock) disable iff (reset) $onehot0(gnt));
    a_rvalid_onehot0:    assert property (@(posedge clock) disable iff (reset) $onehot0(rvalid));
    a_wdone_onehot0:     assert property (@(posedge clock) disable iff (reset) $onehot0(wdone));
    a_busy_state:        assert property (@(posedge clock) disable iff (reset)
        busy == (state != IDLE));

endmodule

// File: rtl/regfile_arbiter.sv
// Shares a register file (fetch / writeback enables, one-cycle registered read) between the core
// pipeline and a debug/DMA port with round-robin arbitration and one operation in flight.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int DataSize    = 32,
    parameter int AddrSize    = 5,
    parameter bit R0Hardwired = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    regfile_arbiter_if.slave    bus,
    output logic [AddrSize-1:0] rf_read_address1,
    output logic [AddrSize-1:0] rf_read_address2,
    output logic [AddrSize-1:0] rf_write_address,
    output logic [DataSize-1:0] rf_write_data,
    output logic                rf_enable_fetch,
    output logic                rf_enable_writeback,
    input  logic [DataSize-1:0] rf_read_data1,
    input  logic [DataSize-1:0] rf_read_data2
);

    state_t              state_r;
    state_t              state_next_s;
    logic                last_gnt_r;
    logic                op_id_r;
    logic [AddrSize-1:0] addr1_r;
    logic [AddrSize-1:0] addr2_r;
    logic [DataSize-1:0] wdata_r;
    logic [DataSize-1:0] rdata1_r;
    logic [DataSize-1:0] rdata2_r;
    logic [1:0]          rvalid_r;
    logic [1:0]          wdone_r;

    logic [1:0]          arb_req_s;
    logic [1:0]          arb_gnt_s;
    logic                winner_s;
    logic                accept_s;
    logic                sel_we_s;
    logic [AddrSize-1:0] sel_addr1_s;
    logic [AddrSize-1:0] sel_addr2_s;
    logic [DataSize-1:0] sel_wdata_s;

    // Requests are only considered while idle, so a held request re-arbitrates after completion
    assign arb_req_s = (state_r == IDLE) ? bus.req : 2'b00;

    rr_arbiter2 u_arb (
        .req      (arb_req_s),
        .last_gnt (last_gnt_r),
        .gnt      (arb_gnt_s),
        .winner   (winner_s)
    );

    assign accept_s    = |arb_gnt_s;
    assign sel_we_s    = winner_s ? bus.we[1] : bus.we[0];
    assign sel_addr1_s = winner_s ? bus.req_addr1[AddrSize +: AddrSize] : bus.req_addr1[0 +: AddrSize];
    assign sel_addr2_s = winner_s ? bus.req_addr2[AddrSize +: AddrSize] : bus.req_addr2[0 +: AddrSize];
    assign sel_wdata_s = winner_s ? bus.req_wdata[DataSize +: DataSize] : bus.req_wdata[0 +: DataSize];

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and register-file enables
    always_comb begin
        state_next_s        = state_r;
        rf_enable_fetch     = 1'b0;
        rf_enable_writeback = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = sel_we_s ? WR : RD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD: begin
                rf_enable_fetch = 1'b1;
                state_next_s    = RD_CAP;
            end
            RD_CAP: begin
                state_next_s = IDLE;
            end
            WR: begin
                if (R0Hardwired && (addr1_r == {AddrSize{1'b0}})) begin
                    rf_enable_writeback = 1'b0;
                end else begin
                    rf_enable_writeback = 1'b1;
                end
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand latch and round-robin pointer, updated on every grant
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_gnt_r <= REQ_DBG;
            op_id_r    <= REQ_CORE;
            addr1_r    <= {AddrSize{1'b0}};
            addr2_r    <= {AddrSize{1'b0}};
            wdata_r    <= {DataSize{1'b0}};
        end else if (accept_s) begin
            last_gnt_r <= winner_s;
            op_id_r    <= winner_s;
            addr1_r    <= sel_addr1_s;
            addr2_r    <= sel_addr2_s;
            wdata_r    <= sel_wdata_s;
        end
    end

    // Responses; read data must be taken in RD_CAP because the regfile clears its outputs at that edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata1_r <= {DataSize{1'b0}};
            rdata2_r <= {DataSize{1'b0}};
            rvalid_r <= 2'b00;
            wdone_r  <= 2'b00;
        end else begin
            rvalid_r <= 2'b00;
            wdone_r  <= 2'b00;
            case (state_r)
                RD_CAP: begin
                    rdata1_r <= rf_read_data1;
                    rdata2_r <= rf_read_data2;
                    rvalid_r <= (op_id_r == REQ_DBG) ? 2'b10 : 2'b01;
                end
                WR: begin
                    wdone_r <= (op_id_r == REQ_DBG) ? 2'b10 : 2'b01;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.gnt          = arb_gnt_s;
    assign bus.rvalid       = rvalid_r;
    assign bus.wdone        = wdone_r;
    assign bus.rdata1       = rdata1_r;
    assign bus.rdata2       = rdata2_r;
    assign bus.busy         = (state_r != IDLE);
    assign rf_read_address1 = addr1_r;
    assign rf_read_address2 = addr2_r;
    assign rf_write_address = addr1_r;
    assign rf_write_data    = wdata_r;

    regfile_arbiter_sva u_sva (
        .clock            (clock),
        .reset            (reset),
        .state            (state_r),
        .busy             (bus.busy),
        .gnt              (bus.gnt),
        .rvalid           (bus.rvalid),
        .wdone            (bus.wdone),
        .enable_fetch     (rf_enable_fetch),
        .enable_writeback (rf_enable_writeback)
    );

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed self-checking bench for regfile_arbiter, driving it against a behavioural register file.
module tb_regfile_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rf_ra1;
    logic [4:0]  rf_ra2;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        rf_fetch;
    logic        rf_wb;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;

    regfile_arbiter_if #(.DataSize(32), .AddrSize(5)) bus ();

    regfile_arbiter #(.DataSize(32), .AddrSize(5), .R0Hardwired(1'b1)) dut (
        .clock               (clock),
        .reset               (reset),
        .bus                 (bus),
        .rf_read_address1    (rf_ra1),
        .rf_read_address2    (rf_ra2),
        .rf_write_address    (rf_wa),
        .rf_write_data       (rf_wd),
        .rf_enable_fetch     (rf_fetch),
        .rf_enable_writeback (rf_wb),
        .rf_read_data1       (rf_rd1),
        .rf_read_data2       (rf_rd2)
    );

    always #5 clock = ~clock;

    // Register file: registered read on fetch, outputs cleared when idle
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            rf_rd1 <= 32'h0;
            rf_rd2 <= 32'h0;
        end else begin
            if (rf_wb) mem[rf_wa] <= rf_wd;
            if (rf_fetch) begin
                rf_rd1 <= mem[rf_ra1];
                rf_rd2 <= mem[rf_ra2];
            end else if (!rf_wb) begin
                rf_rd1 <= 32'h0;
                rf_rd2 <= 32'h0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int id, input logic w, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [31:0] wd);
        bus.we[id]                = w;
        bus.req_addr1[id*5 +: 5]  = a1;
        bus.req_addr2[id*5 +: 5]  = a2;
        bus.req_wdata[id*32 +: 32] = wd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 2'b00; bus.we = 2'b00;
        bus.req_addr1 = '0; bus.req_addr2 = '0; bus.req_wdata = '0;
        tick(); tick();
        checks++; if ({bus.gnt, bus.rvalid, bus.wdone, bus.busy} !== 7'b0) begin
            errors++; $display("FAIL reset_pulses: got %b expected 0", {bus.gnt, bus.rvalid, bus.wdone, bus.busy}); end
        checks++; if ({rf_fetch, rf_wb, rf_ra1, rf_ra2, rf_wa, rf_wd} !== 49'b0) begin
            errors++; $display("FAIL reset_rf: got %h expected 0", {rf_fetch, rf_wb, rf_ra1, rf_ra2, rf_wa, rf_wd}); end
        checks++; if ({bus.rdata1, bus.rdata2} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", {bus.rdata1, bus.rdata2}); end
        reset = 1'b0;
        tick();
        set_op(0, 1'b0, 5'd3, 5'd4, 32'h0);
        bus.req = 2'b01;
        #1;
        checks++; if (bus.gnt !== 2'b01) begin
            errors++; $display("FAIL t1_gnt: got %b expected 01", bus.gnt); end
        tick();
        bus.req = 2'b00;
        #1;
        checks++; if ({rf_fetch, rf_ra1, rf_ra2, bus.busy, bus.gnt} !== {1'b1, 5'd3, 5'd4, 1'b1, 2'b00}) begin
            errors++; $display("FAIL t1_fetch: got %b_%0d_%0d_%b_%b expected 1_3_4_1_00", rf_fetch, rf_ra1, rf_ra2, bus.busy, bus.gnt); end
        tick();
        checks++; if ({rf_fetch, bus.rvalid} !== 3'b000) begin
            errors++; $display("FAIL t1_rdcap: got %b expected 000", {rf_fetch, bus.rvalid}); end
        tick();
        checks++; if ({bus.rvalid, bus.busy} !== 3'b010 || bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            errors++; $display("FAIL t1_rvalid: got %b %h %h expected 010 0 0", {bus.rvalid, bus.busy}, bus.rdata1, bus.rdata2); end
        tick();
        checks++; if (bus.rvalid !== 2'b00) begin
            errors++; $display("FAIL t1_rvalid_pulse: got %b expected 00", bus.rvalid); end
    endtask

    task automatic test_write_read();
        set_op(0, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF);
        bus.req = 2'b01;
        #1;
        checks++; if (bus.gnt !== 2'b01) begin
            errors++; $display("FAIL t2_wgnt: got %b expected 01", bus.gnt); end
        tick();
        bus.req = 2'b00;
        #1;
        checks++; if ({rf_wb, rf_fetch, rf_wa, rf_wd} !== {1'b1, 1'b0, 5'd5, 32'hDEADBEEF}) begin
            errors++; $display("FAIL t2_wb: got %b_%b_%0d_%h expected 1_0_5_deadbeef", rf_wb, rf_fetch, rf_wa, rf_wd); end
        tick();
        checks++; if (bus.wdone !== 2'b01) begin
            errors++; $display("FAIL t2_wdone: got %b expected 01", bus.wdone); end
        set_op(0, 1'b0, 5'd5, 5'd5, 32'h0);
        bus.req = 2'b01;
        #1;
        checks++; if (bus.gnt !== 2'b01) begin
            errors++; $display("FAIL t2_b2b_gnt: got %b expected 01", bus.gnt); end
        tick();
        bus.req = 2'b00;
        tick(); tick();
        checks++; if (bus.rvalid !== 2'b01 || bus.rdata1 !== 32'hDEADBEEF || bus.rdata2 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL t2_read: got %b %h %h expected 01 deadbeef deadbeef", bus.rvalid, bus.rdata1, bus.rdata2); end
        set_op(1, 1'b1, 5'd7, 5'd0, 32'hCAFEF00D);
        bus.req = 2'b10;
        #1;
        checks++; if (bus.gnt !== 2'b10) begin
            errors++; $display("FAIL t2_dbg_gnt: got %b expected 10", bus.gnt); end
        tick();
        bus.req = 2'b00;
        tick();
        checks++; if (bus.wdone !== 2'b10) begin
            errors++; $display("FAIL t2_dbg_wdone: got %b expected 10", bus.wdone); end
        set_op(1, 1'b0, 5'd5, 5'd7, 32'h0);
        bus.req = 2'b10;
        tick();
        bus.req = 2'b00;
        tick(); tick();
        checks++; if (bus.rvalid !== 2'b10 || bus.rdata1 !== 32'hDEADBEEF || bus.rdata2 !== 32'hCAFEF00D) begin
            errors++; $display("FAIL t2_dbg_read: got %b %h %h expected 10 deadbeef cafef00d", bus.rvalid, bus.rdata1, bus.rdata2); end
    endtask

    task automatic test_tie();
        logic [1:0] exp_g  [11] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
        logic [1:0] exp_rv [11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        logic [1:0] exp_wd [11] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        set_op(0, 1'b1, 5'd9, 5'd0, 32'h11112222);
        set_op(1, 1'b0, 5'd9, 5'd9, 32'h0);
        bus.req = 2'b11;
        for (int c = 0; c < 11; c++) begin
            #1;
            checks++; if ({bus.gnt, bus.rvalid, bus.wdone} !== {exp_g[c], exp_rv[c], exp_wd[c]}) begin
                errors++; $display("FAIL tie_c%0d: got gnt/rvalid/wdone %b expected %b", c,
                                   {bus.gnt, bus.rvalid, bus.wdone}, {exp_g[c], exp_rv[c], exp_wd[c]}); end
            if (exp_rv[c] != 2'b00) begin
                checks++; if (bus.rdata1 !== 32'h11112222) begin
                    errors++; $display("FAIL tie_rdata_c%0d: got %h expected 11112222", c, bus.rdata1); end
            end
            tick();
        end
        bus.req = 2'b00;
        tick(); tick();
    endtask

    task automatic test_r0();
        logic seen_wb = 1'b0;
        set_op(0, 1'b1, 5'd0, 5'd0, 32'h00001234);
        bus.req = 2'b01;
        #1;
        checks++; if (bus.gnt !== 2'b01) begin
            errors++; $display("FAIL r0_gnt: got %b expected 01", bus.gnt); end
        seen_wb = rf_wb;
        tick();
        bus.req = 2'b00;
        #1;
        seen_wb = seen_wb | rf_wb;
        tick();
        seen_wb = seen_wb | rf_wb;
        checks++; if ({bus.wdone, seen_wb} !== 3'b010) begin
            errors++; $display("FAIL r0_write: got wdone/wb %b expected 010", {bus.wdone, seen_wb}); end
        set_op(0, 1'b0, 5'd0, 5'd0, 32'h0);
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        tick(); tick();
        checks++; if (bus.rvalid !== 2'b01 || bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            errors++; $display("FAIL r0_read: got %b %h %h expected 01 0 0", bus.rvalid, bus.rdata1, bus.rdata2); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        set_op(0, 1'b0, 5'd9, 5'd9, 32'h0);
        bus.req = 2'b01;
        #1;
        checks++; if (bus.gnt !== 2'b01) begin
            errors++; $display("FAIL mid_gnt: got %b expected 01", bus.gnt); end
        tick();
        bus.req = 2'b00;
        tick();
        reset = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.rvalid, rf_fetch} !== 4'b0) begin
            errors++; $display("FAIL mid_reset: got %b expected 0000", {bus.busy, bus.rvalid, rf_fetch}); end
        tick();
        reset = 1'b0;
        checks++; if (bus.rvalid !== 2'b00 || bus.rdata1 !== 32'h0) begin
            errors++; $display("FAIL mid_no_resp: got %b %h expected 00 0", bus.rvalid, bus.rdata1); end
        tick();
        checks++; if (bus.rvalid !== 2'b00) begin
            errors++; $display("FAIL mid_no_late_resp: got %b expected 00", bus.rvalid); end
        set_op(0, 1'b0, 5'd1, 5'd1, 32'h0);
        set_op(1, 1'b0, 5'd1, 5'd1, 32'h0);
        bus.req = 2'b11;
        #1;
        checks++; if (bus.gnt !== 2'b01) begin
            errors++; $display("FAIL mid_tie_gnt: got %b expected 01", bus.gnt); end
        tick();
        bus.req = 2'b00;
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_r0();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
